// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, register-file
// read, RAW scoreboard and a single ID/EX pipeline register with valid/ready.
// Optional feature: define ID_WB_BYPASS_EN to forward writeback data into the
// operands and let the forwarded register resolve its pending hazard.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  // Fetch side
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  // Register-file read side
  output logic [4:0]  rf_src1,
  output logic [4:0]  rf_src2,
  input  logic [31:0] rf_read1,
  input  logic [31:0] rf_read2,
  // Writeback side
  input  logic        wb_valid,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  // Execute side
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b,
  output logic        ex_illegal,
  input  logic        flush
);

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtIll} fmt_e;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  fmt_e        fmt;
  logic [31:0] imm;
  logic        use_rs1, use_rs2, reg_write;
  logic        byp1, byp2;
  logic [31:0] op1, op2;
  logic        hazard;
  logic        accept, handoff;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] ex_pc_q, ex_op1_q, ex_op2_q, ex_imm_q;
  logic [4:0]  ex_dest_q;
  logic        ex_reg_write_q;
  logic [6:0]  ex_opcode_q;
  logic [2:0]  ex_funct3_q;
  logic        ex_funct7b_q, ex_illegal_q;

  assign opcode  = if_instr[6:0];
  assign rd      = if_instr[11:7];
  assign rs1     = if_instr[19:15];
  assign rs2     = if_instr[24:20];
  assign rf_src1 = rs1;
  assign rf_src2 = rs2;

  // Opcode classification into instruction format
  always_comb begin
    fmt = FmtIll;
    case (opcode)
      7'b0110011:                         fmt = FmtR;
      7'b0000011, 7'b0010011, 7'b1100111: fmt = FmtI;
      7'b0100011:                         fmt = FmtS;
      7'b1100011:                         fmt = FmtB;
      7'b0110111, 7'b0010111:             fmt = FmtU;
      7'b1101111:                         fmt = FmtJ;
      default:                            fmt = FmtIll;
    endcase
  end

  // Immediate generation and source/destination usage per format
  always_comb begin
    imm       = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    reg_write = 1'b0;
    unique case (fmt)
      FmtR: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        reg_write = (rd != '0);
      end
      FmtI: begin
        imm       = {{20{if_instr[31]}}, if_instr[31:20]};
        use_rs1   = 1'b1;
        reg_write = (rd != '0);
      end
      FmtS: begin
        imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FmtB: begin
        imm     = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FmtU: begin
        imm       = {if_instr[31:12], 12'b0};
        reg_write = (rd != '0);
      end
      FmtJ: begin
        imm       = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                     if_instr[30:21], 1'b0};
        reg_write = (rd != '0);
      end
      default: ;
    endcase
  end

`ifdef ID_WB_BYPASS_EN
  // Writeback in the same cycle supplies the operand directly
  assign byp1 = wb_valid && (wb_dest == rs1) && (rs1 != '0);
  assign byp2 = wb_valid && (wb_dest == rs2) && (rs2 != '0);
`else
  logic unused_wb_data;
  assign byp1           = 1'b0;
  assign byp2           = 1'b0;
  assign unused_wb_data = ^wb_data;
`endif

  // Operand select: x0 and unused sources read as zero
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (use_rs1 && rs1 != '0) op1 = byp1 ? wb_data : rf_read1;
    if (use_rs2 && rs2 != '0) op2 = byp2 ? wb_data : rf_read2;
  end

  // RAW hazard: outstanding writer in the scoreboard or sitting in ID/EX
  always_comb begin
    hazard = 1'b0;
    if (use_rs1 && rs1 != '0) begin
      if ((pending_q[rs1] && !byp1) ||
          (ex_valid_q && ex_reg_write_q && ex_dest_q == rs1)) hazard = 1'b1;
    end
    if (use_rs2 && rs2 != '0) begin
      if ((pending_q[rs2] && !byp2) ||
          (ex_valid_q && ex_reg_write_q && ex_dest_q == rs2)) hazard = 1'b1;
    end
  end

  assign if_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  assign handoff  = ex_valid_q && ex_ready && !flush;

  // Next-state for the valid flag and the pending scoreboard
  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush)        ex_valid_d = 1'b0;
    else if (accept)  ex_valid_d = 1'b1;
    else if (handoff) ex_valid_d = 1'b0;

    pending_d = pending_q;
    if (wb_valid && wb_dest != '0) pending_d[wb_dest] = 1'b0;
    // Set after clear so a same-cycle issue of the same register wins
    if (handoff && ex_reg_write_q) pending_d[ex_dest_q] = 1'b1;
  end

  // ID/EX register and scoreboard state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      pending_q      <= '0;
      ex_pc_q        <= '0;
      ex_op1_q       <= '0;
      ex_op2_q       <= '0;
      ex_imm_q       <= '0;
      ex_dest_q      <= '0;
      ex_reg_write_q <= 1'b0;
      ex_opcode_q    <= '0;
      ex_funct3_q    <= '0;
      ex_funct7b_q   <= 1'b0;
      ex_illegal_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      pending_q  <= pending_d;
      if (accept) begin
        ex_pc_q        <= if_pc;
        ex_op1_q       <= op1;
        ex_op2_q       <= op2;
        ex_imm_q       <= imm;
        ex_dest_q      <= reg_write ? rd : 5'd0;
        ex_reg_write_q <= reg_write;
        ex_opcode_q    <= opcode;
        ex_funct3_q    <= if_instr[14:12];
        ex_funct7b_q   <= if_instr[30];
        ex_illegal_q   <= (fmt == FmtIll);
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_op1       = ex_op1_q;
  assign ex_op2       = ex_op2_q;
  assign ex_imm       = ex_imm_q;
  assign ex_dest      = ex_dest_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7b   = ex_funct7b_q;
  assign ex_illegal   = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural pipeline/scoreboard model.
module tb_decode_stage;

`ifdef ID_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk, rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_src1, rf_src2;
  logic [31:0] rf_read1, rf_read2;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b, ex_illegal, flush;

  int n_checks = 0;
  int n_pass   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_read1(rf_read1), .rf_read2(rf_read2),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b(ex_funct7b),
    .ex_illegal(ex_illegal), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode, written from the ISA format rules
  typedef struct {
    bit          legal;
    bit          u1, u2, we;
    logic [4:0]  dest;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t ref_decode(logic [31:0] ins);
    dec_t d;
    int   v;
    d = '{legal: 1'b1, u1: 1'b0, u2: 1'b0, we: 1'b0, dest: 5'd0, imm: 32'd0};
    case (ins[6:0])
      7'h33: begin d.u1 = 1; d.u2 = 1; d.we = 1; end
      7'h03, 7'h13, 7'h67: begin
        d.u1 = 1; d.we = 1; v = $signed(ins[31:20]); d.imm = v;
      end
      7'h23: begin
        d.u1 = 1; d.u2 = 1; v = $signed({ins[31:25], ins[11:7]}); d.imm = v;
      end
      7'h63: begin
        d.u1 = 1; d.u2 = 1;
        v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); d.imm = v;
      end
      7'h37, 7'h17: begin d.we = 1; d.imm = ins & 32'hFFFF_F000; end
      7'h6f: begin
        d.we = 1;
        v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); d.imm = v;
      end
      default: d.legal = 0;
    endcase
    if (ins[11:7] == 5'd0) d.we = 0;
    if (d.we) d.dest = ins[11:7];
    return d;
  endfunction

  // Behavioural model state
  bit          m_valid;
  bit          m_pend [32];
  logic [31:0] m_pc, m_op1, m_op2, m_imm;
  logic [4:0]  m_dest;
  bit          m_we, m_f7b, m_ill;
  logic [6:0]  m_opc;
  logic [2:0]  m_f3;
  logic [4:0]  inflight [$];

  function automatic logic [31:0] pend_vec();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = m_pend[i];
    return p;
  endfunction

  function automatic bit stalls_on(logic [4:0] s);
    bit fwd;
    fwd = Byp && wb_valid && (wb_dest == s);
    return (m_pend[s] && !fwd) || (m_valid && m_we && m_dest == s);
  endfunction

  function automatic logic [31:0] operand(bit used, logic [4:0] s, logic [31:0] rf);
    if (!used || s == 5'd0) return 32'd0;
    if (Byp && wb_valid && wb_dest == s) return wb_data;
    return rf;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_instr = 0; if_pc = 0; rf_read1 = 0; rf_read2 = 0;
    wb_valid = 0; wb_dest = 0; wb_data = 0; ex_ready = 1; flush = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    tick();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    #1;
    n_checks++;
    if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid);
    else n_pass++;
    n_checks++;
    if ({ex_pc, ex_op1, ex_imm, ex_dest} !== '0)
      $display("FAIL reset_regs: got %h/%h/%h/%h want 0", ex_pc, ex_op1, ex_imm, ex_dest);
    else n_pass++;
    tick();
    rst = 1;
    if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h40;
    tick();
    if_instr = 32'h00100313;
    tick();
    n_checks++;
    if (dut.pending_q !== 32'h20) $display("FAIL reset_pre_pend: got %h want 20", dut.pending_q);
    else n_pass++;
    // Asynchronous reset mid-cycle with an instruction in ID/EX
    rst = 0;
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || dut.pending_q !== 32'd0 || ex_dest !== 5'd0)
      $display("FAIL reset_async: got v=%b pend=%h dest=%0d want 0/0/0",
               ex_valid, dut.pending_q, ex_dest);
    else n_pass++;
    rst = 1;
    if_instr = 32'h00300393;
    #1;
    n_checks++;
    if (if_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_dest !== 5'd7)
      $display("FAIL reset_first_accept: got v=%b dest=%0d want 1/7", ex_valid, ex_dest);
    else n_pass++;
  endtask

  task automatic test_decode();
    do_reset();
    if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h100;
    rf_read1 = 32'h1234_5678; rf_read2 = 32'h0000_DEAD;
    #1;
    n_checks++;
    if (if_ready !== 1'b1 || rf_src1 !== 5'd0)
      $display("FAIL addi_ready: got rdy=%b src1=%0d want 1/0", if_ready, rf_src1);
    else n_pass++;
    tick();
    n_checks++;
    if (ex_valid !== 1 || ex_imm !== 32'hFFFF_FFFF || ex_dest !== 5'd5 ||
        ex_reg_write !== 1 || ex_op1 !== 32'd0 || ex_pc !== 32'h100 || ex_opcode !== 7'h13)
      $display("FAIL addi_decode: got v=%b imm=%h dest=%0d we=%b op1=%h pc=%h opc=%h",
               ex_valid, ex_imm, ex_dest, ex_reg_write, ex_op1, ex_pc, ex_opcode);
    else n_pass++;
    if_instr = 32'h00112423; if_pc = 32'h104;
    #1;
    n_checks++;
    if (if_ready !== 1'b1 || rf_src1 !== 5'd2 || rf_src2 !== 5'd1)
      $display("FAIL sw_ready: got rdy=%b src=%0d,%0d want 1 2,1", if_ready, rf_src1, rf_src2);
    else n_pass++;
    tick();
    n_checks++;
    if (ex_reg_write !== 0 || ex_imm !== 32'd8 || ex_op1 !== 32'h1234_5678 ||
        ex_op2 !== 32'h0000_DEAD || ex_funct3 !== 3'd2)
      $display("FAIL sw_decode: got we=%b imm=%h op1=%h op2=%h f3=%0d",
               ex_reg_write, ex_imm, ex_op1, ex_op2, ex_funct3);
    else n_pass++;
    if_valid = 0;
    tick();
    n_checks++;
    if (dut.pending_q !== 32'h20 || ex_valid !== 1'b0)
      $display("FAIL sw_no_pend: got pend=%h v=%b want 20/0", dut.pending_q, ex_valid);
    else n_pass++;
  endtask

  task automatic test_raw_stall();
    do_reset();
    if_valid = 1; if_instr = 32'h002081B3;  // add x3,x1,x2
    tick();
    if_instr = 32'h00318233;                // add x4,x3,x3
    #1;
    n_checks++;
    if (if_ready !== 1'b0) $display("FAIL raw_ex_stall: got %b want 0", if_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (if_ready !== 1'b0 || ex_valid !== 1'b0 || dut.pending_q !== 32'h8)
      $display("FAIL raw_pend_stall: got rdy=%b v=%b pend=%h want 0/0/8",
               if_ready, ex_valid, dut.pending_q);
    else n_pass++;
    tick();
    n_checks++;
    if (if_ready !== 1'b0) $display("FAIL raw_hold: got %b want 0", if_ready);
    else n_pass++;
    wb_valid = 1; wb_dest = 3; wb_data = 32'hCAFE_F00D;
    rf_read1 = 32'h1111_2222; rf_read2 = 32'h1111_2222;
    #1;
`ifdef ID_WB_BYPASS_EN
    n_checks++;
    if (if_ready !== 1'b1) $display("FAIL raw_bypass_ready: got %b want 1", if_ready);
    else n_pass++;
    tick();
    wb_valid = 0;
    n_checks++;
    if (ex_valid !== 1 || ex_op1 !== 32'hCAFE_F00D || ex_op2 !== 32'hCAFE_F00D)
      $display("FAIL raw_bypass_ops: got v=%b op1=%h op2=%h want 1 cafef00d",
               ex_valid, ex_op1, ex_op2);
    else n_pass++;
`else
    n_checks++;
    if (if_ready !== 1'b0) $display("FAIL raw_wb_cycle: got %b want 0", if_ready);
    else n_pass++;
    tick();
    wb_valid = 0;
    #1;
    n_checks++;
    if (if_ready !== 1'b1) $display("FAIL raw_release: got %b want 1", if_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (ex_valid !== 1 || ex_op1 !== 32'h1111_2222 || ex_op2 !== 32'h1111_2222)
      $display("FAIL raw_rf_ops: got v=%b op1=%h op2=%h want 1 11112222",
               ex_valid, ex_op1, ex_op2);
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    ex_ready = 0;
    if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h200;
    tick();
    if_instr = 32'h00100313; if_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (if_ready !== 0 || ex_valid !== 1 || ex_pc !== 32'h200 || ex_dest !== 5'd5 ||
          ex_imm !== 32'hFFFF_FFFF || dut.pending_q !== 32'd0)
        $display("FAIL bp_hold%0d: got rdy=%b v=%b pc=%h dest=%0d imm=%h pend=%h",
                 i, if_ready, ex_valid, ex_pc, ex_dest, ex_imm, dut.pending_q);
      else n_pass++;
      tick();
    end
    ex_ready = 1; if_valid = 0;
    tick();
    n_checks++;
    if (ex_valid !== 0 || dut.pending_q !== 32'h20)
      $display("FAIL bp_release: got v=%b pend=%h want 0/20", ex_valid, dut.pending_q);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    if_valid = 1; if_instr = 32'h00300393;  // addi x7,x0,3
    tick();
    n_checks++;
    if (ex_valid !== 1 || ex_dest !== 5'd7)
      $display("FAIL flush_setup: got v=%b dest=%0d want 1/7", ex_valid, ex_dest);
    else n_pass++;
    flush = 1; if_instr = 32'h00100313;
    #1;
    n_checks++;
    if (if_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", if_ready);
    else n_pass++;
    tick();
    flush = 0; if_valid = 0;
    n_checks++;
    if (ex_valid !== 0 || dut.pending_q !== 32'd0)
      $display("FAIL flush_kill: got v=%b pend=%h want 0/0", ex_valid, dut.pending_q);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_valid = 1; if_instr = 32'h00100493;  // addi x9,x0,1
    tick();
    if_valid = 0; wb_valid = 1; wb_dest = 9;
    tick();
    wb_valid = 0;
    n_checks++;
    if (dut.pending_q !== 32'h200)
      $display("FAIL simul_set_wins: got pend=%h want 200", dut.pending_q);
    else n_pass++;
    // Writeback to x0 must be ignored and flush must not clear pending
    flush = 1; wb_valid = 1; wb_dest = 0;
    tick();
    flush = 0; wb_valid = 0;
    n_checks++;
    if (dut.pending_q !== 32'h200)
      $display("FAIL pend_persist: got pend=%h want 200", dut.pending_q);
    else n_pass++;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [10] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                              7'h6f, 7'h0b};
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(9)];
    ins[11:7]  = 5'($urandom_range(7));
    ins[19:15] = 5'($urandom_range(7));
    ins[24:20] = 5'($urandom_range(7));
    return ins;
  endfunction

  task automatic test_random();
    dec_t        d;
    bit          hz, exp_rdy, acc, hand;
    logic [4:0]  s1, s2;
    logic [31:0] e1, e2;
    do_reset();
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    inflight.delete();
    for (int c = 0; c < 1500; c++) begin
      if_valid = ($urandom_range(3) != 0);
      if_instr = gen_instr();
      if_pc    = $urandom;
      rf_read1 = $urandom;
      rf_read2 = $urandom;
      ex_ready = ($urandom_range(3) != 0);
      flush    = ($urandom_range(11) == 0);
      wb_valid = 0; wb_dest = 0; wb_data = $urandom;
      if (inflight.size() > 0 && $urandom_range(2) == 0) begin
        wb_valid = 1; wb_dest = inflight.pop_front();
      end else if ($urandom_range(15) == 0) begin
        wb_valid = 1; wb_dest = 5'($urandom_range(7));
      end
      #1;
      d  = ref_decode(if_instr);
      s1 = if_instr[19:15];
      s2 = if_instr[24:20];
      hz = (d.u1 && s1 != 0 && stalls_on(s1)) || (d.u2 && s2 != 0 && stalls_on(s2));
      exp_rdy = (!m_valid || ex_ready) && !hz && !flush;
      n_checks++;
      if (if_ready !== exp_rdy || rf_src1 !== s1 || rf_src2 !== s2)
        $display("FAIL rand_ready c%0d: got rdy=%b src=%0d,%0d want %b %0d,%0d",
                 c, if_ready, rf_src1, rf_src2, exp_rdy, s1, s2);
      else n_pass++;
      acc  = if_valid && exp_rdy;
      hand = m_valid && ex_ready && !flush;
      e1   = operand(d.u1, s1, rf_read1);
      e2   = operand(d.u2, s2, rf_read2);
      if (wb_valid && wb_dest != 0) m_pend[wb_dest] = 0;
      if (hand && m_we) begin
        m_pend[m_dest] = 1;
        inflight.push_back(m_dest);
      end
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_pc = if_pc; m_op1 = e1; m_op2 = e2; m_imm = d.imm;
        m_dest = d.dest; m_we = d.we; m_opc = if_instr[6:0]; m_f3 = if_instr[14:12];
        m_f7b = if_instr[30]; m_ill = !d.legal;
      end else if (hand) m_valid = 0;
      tick();
      n_checks++;
      if (ex_valid !== m_valid || dut.pending_q !== pend_vec())
        $display("FAIL rand_state c%0d: got v=%b pend=%h want %b %h",
                 c, ex_valid, dut.pending_q, m_valid, pend_vec());
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if ({ex_pc, ex_op1, ex_op2, ex_imm, ex_dest, ex_reg_write, ex_opcode, ex_funct3,
             ex_funct7b, ex_illegal} !==
            {m_pc, m_op1, m_op2, m_imm, m_dest, m_we, m_opc, m_f3, m_f7b, m_ill})
          $display("FAIL rand_payload c%0d: got pc=%h op=%h,%h imm=%h d=%0d we=%b ill=%b want pc=%h op=%h,%h imm=%h d=%0d we=%b ill=%b",
                   c, ex_pc, ex_op1, ex_op2, ex_imm, ex_dest, ex_reg_write, ex_illegal,
                   m_pc, m_op1, m_op2, m_imm, m_dest, m_we, m_ill);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_raw_stall();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
